// File: rtl/alu_multicycle_pkg.sv
// Shared op encodings, FSM states and flag payload for the multicycle EX ALU.
package alu_multicycle_pkg;

  localparam int unsigned WORD  = 64;
  localparam int unsigned CTL_W = 4;

  typedef enum logic [CTL_W-1:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_LSL  = 4'h4,
    ALU_LSR  = 4'h5,
    ALU_SUB  = 4'h6,
    ALU_PASS = 4'h7,
    ALU_MUL  = 4'h8,
    ALU_UDIV = 4'h9,
    ALU_SDIV = 4'hA,
    ALU_ASR  = 4'hB,
    ALU_NOR  = 4'hC
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic co;
  } alu_flags_t;

  // Ops that iterate one bit per cycle instead of finishing in one.
  function automatic logic is_iter_op(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_UDIV) || (op == ALU_SDIV);
  endfunction

endpackage

// File: rtl/alu_multicycle_div.sv
// Unsigned restoring divider, one quotient bit per cycle; exposes next-step quotient.
module alu_iter_div
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = WORD,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot_c,
  output logic             done_c
);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;

  // Dividend bits shift out of quo into rem while quotient bits shift in.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    fits     = ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_c   = {quo[WIDTH-2:0], fits};
    done_c   = running && (count == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
    end else if (running) begin
      rem     <= rem_next;
      quo     <= quot_c;
      count   <= count + CNT_W'(1);
      if (done_c) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle EX ALU: single-cycle logic/arith/shift ops plus iterative MUL/UDIV/SDIV
// behind valid/ready handshakes on request and result sides.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH   = WORD,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CTL_W-1:0] ALUCtl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Co
);

  state_e             state, state_next;
  alu_op_e            op_in, op_q;
  logic               accept_c, load_res_c;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   mcand, mplier, acc, acc_next;
  logic               neg_q, bzero_q, sdiv_ovf_q;
  logic               div_start_c, div_done_c;
  logic [WIDTH-1:0]   div_dvd, div_dvs, quot_c;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH-1:0]   simple_res, iter_res, res_c;
  logic               simple_ovf, simple_co, iter_ovf, ovf_c, co_c;
  alu_flags_t         flags_q;

  assign op_in = alu_op_e'(ALUCtl);
  assign shamt = b[SHAMT_W-1:0];

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    load_res_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          if (is_iter_op(op_in)) begin
            state_next = ST_BUSY;
          end else begin
            state_next = ST_DONE;
            load_res_c = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if ((op_q == ALU_MUL) ? (count == SHAMT_W'(WIDTH - 1)) : div_done_c) begin
          state_next = ST_DONE;
          load_res_c = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_DONE);
    end
  end

  // Signed division runs on magnitudes; the sign is restored on the quotient.
  assign div_start_c = accept_c && ((op_in == ALU_UDIV) || (op_in == ALU_SDIV));
  assign div_dvd     = ((op_in == ALU_SDIV) && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
  assign div_dvs     = ((op_in == ALU_SDIV) && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

  alu_iter_div #(
    .WIDTH (WIDTH),
    .CNT_W (SHAMT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .quot_c   (quot_c),
    .done_c   (div_done_c)
  );

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= ALU_AND;
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg_q      <= 1'b0;
      bzero_q    <= 1'b0;
      sdiv_ovf_q <= 1'b0;
    end else if (accept_c) begin
      op_q       <= op_in;
      count      <= '0;
      mcand      <= a;
      mplier     <= b;
      acc        <= '0;
      neg_q      <= a[WIDTH-1] ^ b[WIDTH-1];
      bzero_q    <= (b == '0);
      sdiv_ovf_q <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end else if (state == ST_BUSY) begin
      count      <= count + SHAMT_W'(1);
      acc        <= acc_next;
      mcand      <= mcand << 1;
      mplier     <= mplier >> 1;
    end
  end

  // Result and flag selection for the op that completes this cycle.
  always_comb begin
    add_sum    = {1'b0, a} + {1'b0, b};
    sub_diff   = {1'b0, a} - {1'b0, b};
    simple_res = '0;
    simple_ovf = 1'b0;
    simple_co  = 1'b0;
    case (op_in)
      ALU_AND:  simple_res = a & b;
      ALU_OR:   simple_res = a | b;
      ALU_XOR:  simple_res = a ^ b;
      ALU_NOR:  simple_res = ~(a | b);
      ALU_PASS: simple_res = b;
      ALU_LSL:  simple_res = a << shamt;
      ALU_LSR:  simple_res = a >> shamt;
      ALU_ASR:  simple_res = $unsigned($signed(a) >>> shamt);
      ALU_ADD: begin
        simple_res = add_sum[WIDTH-1:0];
        simple_co  = add_sum[WIDTH];
        simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        simple_res = sub_diff[WIDTH-1:0];
        simple_co  = ~sub_diff[WIDTH];
        simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: simple_res = '0;
    endcase

    iter_res = '0;
    iter_ovf = 1'b0;
    case (op_q)
      ALU_MUL:  iter_res = acc_next;
      ALU_UDIV: iter_res = bzero_q ? '0 : quot_c;
      ALU_SDIV: begin
        iter_res = bzero_q ? '0 : (neg_q ? (WIDTH'(0) - quot_c) : quot_c);
        iter_ovf = sdiv_ovf_q;
      end
      default: iter_res = '0;
    endcase

    if (state == ST_IDLE) begin
      res_c = simple_res;
      ovf_c = simple_ovf;
      co_c  = simple_co;
    end else begin
      res_c = iter_res;
      ovf_c = iter_ovf;
      co_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUOut  <= '0;
      flags_q <= '0;
    end else if (load_res_c) begin
      ALUOut           <= res_c;
      flags_q.zero     <= (res_c == '0);
      flags_q.negative <= res_c[WIDTH-1];
      flags_q.overflow <= ovf_c;
      flags_q.co       <= co_c;
    end
  end

  assign Zero     = flags_q.zero;
  assign Negative = flags_q.negative;
  assign Overflow = flags_q.overflow;
  assign Co       = flags_q.co;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH=64.
module tb_alu_multicycle;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_LSL  = 4'h4;
  localparam logic [3:0] OP_LSR  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_PASS = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_UDIV = 4'h9;
  localparam logic [3:0] OP_SDIV = 4'hA;
  localparam logic [3:0] OP_ASR  = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        ovf;
    logic        co;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, alu_out;
  logic [3:0]  ctl;
  logic        zero, negative, overflow, co;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUCtl    (ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOut    (alu_out),
    .Zero      (zero),
    .Negative  (negative),
    .Overflow  (overflow),
    .Co        (co)
  );

  // Issue one request from IDLE; returns the cycle (1 = cycle after accept) out_valid is seen.
  task automatic do_op(input logic [3:0] op, input logic [63:0] xa, input logic [63:0] xb,
                       output int lat);
    @(negedge clk);
    ctl = op; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL timeout op=%h: out_valid never rose", op);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ctl = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, alu_out, zero, negative, overflow, co} !== 69'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b out=%h z%b n%b o%b c%b want all 0",
               out_valid, alu_out, zero, negative, overflow, co);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    do_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    total++;
    if ({alu_out, zero, negative, overflow, co} !== {MIN64, 4'b0110}) begin
      bad++;
      $display("FAIL add_ovf: got %h z%b n%b o%b c%b want %h z0 n1 o1 c0",
               alu_out, zero, negative, overflow, co, MIN64);
    end
    consume();
  endtask

  task automatic test_sub();
    int lat;
    do_op(OP_SUB, 64'd5, 64'd5, lat);
    total++;
    if ({alu_out, zero, negative, overflow, co} !== {64'd0, 4'b1001}) begin
      bad++;
      $display("FAIL sub_equal: got %h z%b n%b o%b c%b want 0 z1 n0 o0 c1",
               alu_out, zero, negative, overflow, co);
    end
    consume();
    do_op(OP_SUB, 64'd3, 64'd5, lat);
    total++;
    if ({alu_out, zero, negative, overflow, co} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b0100}) begin
      bad++;
      $display("FAIL sub_neg: got %h z%b n%b o%b c%b want fffffffffffffffe z0 n1 o0 c0",
               alu_out, zero, negative, overflow, co);
    end
    consume();
  endtask

  task automatic test_logic_shift();
    vec_t v[14];
    int   lat;
    logic [63:0] a1, b1;
    a1 = 64'h00FF_00FF_1234_5678;
    b1 = 64'h0F0F_0F0F_0000_FFFF;
    v[0]  = '{OP_AND,  a1, b1, 64'h000F_000F_0000_5678, 1'b0, 1'b0};
    v[1]  = '{OP_OR,   a1, b1, 64'h0FFF_0FFF_1234_FFFF, 1'b0, 1'b0};
    v[2]  = '{OP_XOR,  a1, b1, 64'h0FF0_0FF0_1234_A987, 1'b0, 1'b0};
    v[3]  = '{OP_NOR,  a1, b1, 64'hF000_F000_EDCB_0000, 1'b0, 1'b0};
    v[4]  = '{OP_PASS, a1, b1, 64'h0F0F_0F0F_0000_FFFF, 1'b0, 1'b0};
    v[5]  = '{OP_LSL,  64'h8000_0000_0000_0001, 64'd65, 64'h0000_0000_0000_0002, 1'b0, 1'b0};
    v[6]  = '{OP_LSR,  64'h8000_0000_0000_0001, 64'd65, 64'h4000_0000_0000_0000, 1'b0, 1'b0};
    v[7]  = '{OP_ASR,  MIN64, 64'd67, 64'hF000_0000_0000_0000, 1'b0, 1'b0};
    v[8]  = '{OP_ASR,  64'h8000_0000_0000_0001, 64'd65, 64'hC000_0000_0000_0000, 1'b0, 1'b0};
    v[9]  = '{4'hF,    a1, b1, 64'd0, 1'b0, 1'b0};
    v[10] = '{OP_ADD,  64'd0, 64'd0, 64'd0, 1'b0, 1'b0};
    v[11] = '{OP_SUB,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    v[12] = '{OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1};
    v[13] = '{OP_SUB,  MIN64, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, lat);
      total++;
      if ({lat == 1, alu_out, zero, negative, overflow, co} !==
          {1'b1, v[i].res, v[i].res == 64'd0, v[i].res[63], v[i].ovf, v[i].co}) begin
        bad++;
        $display("FAIL vec%0d op=%h: got lat=%0d %h z%b n%b o%b c%b want lat=1 %h o%b c%b",
                 i, v[i].op, lat, alu_out, zero, negative, overflow, co,
                 v[i].res, v[i].ovf, v[i].co);
      end
      consume();
    end
  endtask

  task automatic test_mul();
    int cyc, low;
    @(negedge clk);
    ctl = OP_MUL; a = 64'hFFFF_FFFF_FFFF_FFFD; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1; low = 0;
    while (!out_valid && cyc < 200) begin
      if (!in_ready) low++;
      if (cyc == 10) begin a = 64'd5; b = 64'd5; ctl = OP_SUB; end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 65 || low !== 64) begin
      bad++;
      $display("FAIL mul_latency: got out_valid cycle %0d busy %0d want 65 64", cyc, low);
    end
    total++;
    if ({alu_out, zero, negative, overflow, co} !== {64'hFFFF_FFFF_FFFF_FFEB, 4'b0100}) begin
      bad++;
      $display("FAIL mul_result: got %h z%b n%b o%b c%b want ffffffffffffffeb z0 n1 o0 c0",
               alu_out, zero, negative, overflow, co);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(OP_MUL, 64'd6, 64'd7, lat);
    ctl = OP_ADD; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, alu_out} !== {2'b01, 64'd42}) begin
        bad++;
        $display("FAIL b2b_blocked%0d: got in_ready=%b out_valid=%b out=%h want 0 1 42",
                 i, in_ready, out_valid, alu_out);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, alu_out} !== {1'b1, 64'd2}) begin
      bad++;
      $display("FAIL b2b_second: got out_valid=%b out=%h want 1 2", out_valid, alu_out);
    end
    consume();
  endtask

  task automatic test_div();
    vec_t v[5];
    int   lat;
    v[0] = '{OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    v[1] = '{OP_UDIV, 64'd7, 64'd0, 64'd0, 1'b0, 1'b0};
    v[2] = '{OP_SDIV, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1'b1, 1'b0};
    v[3] = '{OP_UDIV, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0};
    v[4] = '{OP_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, lat);
      total++;
      if ({lat == 65, alu_out, zero, negative, overflow, co} !==
          {1'b1, v[i].res, v[i].res == 64'd0, v[i].res[63], v[i].ovf, 1'b0}) begin
        bad++;
        $display("FAIL div%0d op=%h: got lat=%0d %h z%b n%b o%b c%b want lat=65 %h o%b",
                 i, v[i].op, lat, alu_out, zero, negative, overflow, co, v[i].res, v[i].ovf);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    int lat;
    do_op(OP_SUB, 64'd3, 64'd5, lat);
    for (int i = 0; i < 10; i++) begin
      a = 64'(i); b = 64'd9; ctl = OP_ADD;
      @(negedge clk);
      total++;
      if ({out_valid, alu_out, zero, negative, overflow, co} !==
          {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100}) begin
        bad++;
        $display("FAIL hold%0d: got v=%b %h z%b n%b o%b c%b want v=1 fffffffffffffffe 0100",
                 i, out_valid, alu_out, zero, negative, overflow, co);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    @(negedge clk);
    ctl = OP_UDIV; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, alu_out, zero, negative, overflow, co} !== {2'b01, 68'd0}) begin
      bad++;
      $display("FAIL rst_mid: got out_valid=%b in_ready=%b out=%h flags=%b%b%b%b want 0 1 0 0000",
               out_valid, in_ready, alu_out, zero, negative, overflow, co);
    end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: got late out_valid=%b want 0", seen);
    end
    do_op(OP_ADD, 64'd2, 64'd3, lat);
    total++;
    if ({lat == 1, alu_out} !== {1'b1, 64'd5}) begin
      bad++;
      $display("FAIL rst_recover: got lat=%0d out=%h want 1 5", lat, alu_out);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_div();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
